// File: rtl/decode_issue_ctrl.sv
// rtl/decode_issue_ctrl.sv - decode-to-execute issue control with register scoreboard and mul/div occupancy sequencer
//
// Ports:
//   clk, reset          clock; synchronous active-low reset
//   id_*                decoded instruction: valid, sources (+use), destination (+wen), mul/div flag
//   wb_valid, wb_rd     register write retiring this cycle
//   flush               redirect from EX, kills the decode-stage instruction
//   issue               decode instruction moves into EX this cycle
//   stall_f, stall_d    hold fetch / decode pipeline registers
//   bubble_e            load a NOP into the EX pipeline register
//   busy_vec            pending-write scoreboard, one bit per register (x0 never set)
//   muldiv_busy         mul/div unit occupied
//   muldiv_done         one-cycle pulse at the end of mul/div occupancy
module decode_issue_ctrl #(
    parameter int NREG       = 32,
    parameter int MULDIV_LAT = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            id_valid,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic            id_use_rs1,
    input  logic            id_use_rs2,
    input  logic [4:0]      id_rd,
    input  logic            id_wen,
    input  logic            id_is_muldiv,
    input  logic            wb_valid,
    input  logic [4:0]      wb_rd,
    input  logic            flush,
    output logic            issue,
    output logic            stall_f,
    output logic            stall_d,
    output logic            bubble_e,
    output logic [NREG-1:0] busy_vec,
    output logic            muldiv_busy,
    output logic            muldiv_done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } md_state_e;

    md_state_e       state_q;
    logic [7:0]      cnt_q;
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    logic [31:0] eb;        // effective busy, widened to the 5-bit index space
    logic [31:0] nb;
    logic        hazard;
    logic        issue_int;
    logic        stall_int;

    always_comb begin
        eb = 32'(busy_q);
        // A retiring write is forwarded by the register file, so it is not a hazard.
        if (wb_valid) begin
            eb[wb_rd] = 1'b0;
        end
        eb[0] = 1'b0;

        hazard = (id_use_rs1 & eb[id_rs1])
               | (id_use_rs2 & eb[id_rs2])
               | (id_wen & (id_rd != 5'd0) & eb[id_rd])
               | (id_is_muldiv & (state_q != S_IDLE));

        issue_int = reset & id_valid & ~hazard & ~flush;
        stall_int = reset & id_valid & hazard & ~flush;

        // eb already carries the writeback clear; the set is applied last so it wins.
        nb = eb;
        if (issue_int && id_wen && (id_rd != 5'd0)) begin
            nb[id_rd] = 1'b1;
        end
        nb[0]  = 1'b0;
        busy_d = nb[NREG-1:0];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            busy_q  <= '0;
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
        end else begin
            busy_q <= busy_d;
            case (state_q)
                S_IDLE: begin
                    if (issue_int && id_is_muldiv) begin
                        state_q <= S_BUSY;
                        // BUSY lasts MULDIV_LAT-1 cycles, DONE one more.
                        cnt_q   <= 8'(MULDIV_LAT - 2);
                    end
                end
                S_BUSY: begin
                    if (cnt_q != 8'd0) begin
                        cnt_q <= cnt_q - 8'd1;
                    end else begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign issue       = issue_int;
    assign stall_f     = stall_int;
    assign stall_d     = stall_int;
    assign bubble_e    = ~issue_int;
    assign busy_vec    = busy_q;
    assign muldiv_busy = (state_q != S_IDLE);
    assign muldiv_done = reset & (state_q == S_DONE);

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// tb/tb_decode_issue_ctrl.sv - scoreboard bench for decode_issue_ctrl against a behavioural model
module tb_decode_issue_ctrl;

    localparam int NREG = 32;
    localparam int LAT  = 8;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            id_valid = 1'b0;
    logic [4:0]      id_rs1 = '0, id_rs2 = '0, id_rd = '0, wb_rd = '0;
    logic            id_use_rs1 = 1'b0, id_use_rs2 = 1'b0, id_wen = 1'b0;
    logic            id_is_muldiv = 1'b0, wb_valid = 1'b0, flush = 1'b0;
    logic            issue, stall_f, stall_d, bubble_e, muldiv_busy, muldiv_done;
    logic [NREG-1:0] busy_vec;

    decode_issue_ctrl #(.NREG(NREG), .MULDIV_LAT(LAT)) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_wen(id_wen), .id_is_muldiv(id_is_muldiv),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
        .issue(issue), .stall_f(stall_f), .stall_d(stall_d), .bubble_e(bubble_e),
        .busy_vec(busy_vec), .muldiv_busy(muldiv_busy), .muldiv_done(muldiv_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        chk_state;
        logic        issue;
        logic        stall;
        logic        bubble;
        logic [31:0] busy;
        logic        mbusy;
        logic        mdone;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: set of registers with a pending write, and the number
    // of cycles the mul/div unit stays occupied from the current cycle on.
    bit   pend[32];
    int   md_left = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got=%0h expected=%0h", name, $time, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("issue",    32'(issue),    32'(e.issue));
                chk("stall_f",  32'(stall_f),  32'(e.stall));
                chk("stall_d",  32'(stall_d),  32'(e.stall));
                chk("bubble_e", 32'(bubble_e), 32'(e.bubble));
                chk("muldiv_done", 32'(muldiv_done), 32'(e.mdone));
                if (e.chk_state) begin
                    chk("busy_vec",    busy_vec,           e.busy);
                    chk("muldiv_busy", 32'(muldiv_busy),   32'(e.mbusy));
                end
            end
        end
    end

    function automatic logic [31:0] pend_vec();
        logic [31:0] v = '0;
        for (int i = 1; i < 32; i++) v[i] = pend[i];
        return v;
    endfunction

    task automatic step(input bit rst_n, input bit v, input int rs1, input bit u1,
                        input int rs2, input bit u2, input int rd, input bit wen,
                        input bit md, input bit wbv, input int wbrd, input bit fl,
                        input bit chk_state = 1'b1);
        exp_t e;
        bit   avail[32];
        bit   raw, waw, strc, iss;
        @(negedge clk);
        reset = rst_n; id_valid = v;
        id_rs1 = 5'(rs1); id_use_rs1 = u1; id_rs2 = 5'(rs2); id_use_rs2 = u2;
        id_rd = 5'(rd); id_wen = wen; id_is_muldiv = md;
        wb_valid = wbv; wb_rd = 5'(wbrd); flush = fl;

        // A register is readable if nothing is pending or its write retires now.
        for (int i = 0; i < 32; i++) avail[i] = !pend[i] || (wbv && wbrd == i) || i == 0;
        raw  = (u1 && !avail[rs1]) || (u2 && !avail[rs2]);
        waw  = wen && rd != 0 && !avail[rd];
        strc = md && md_left > 0;
        iss  = rst_n && v && !(raw || waw || strc) && !fl;

        e.chk_state = chk_state;
        e.issue  = iss;
        e.stall  = rst_n && v && (raw || waw || strc) && !fl;
        e.bubble = !iss;
        e.busy   = pend_vec();
        e.mbusy  = md_left > 0;
        e.mdone  = rst_n && md_left == 1;
        exp_q.push_back(e);

        @(posedge clk);
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) pend[i] = 0;
            md_left = 0;
        end else begin
            if (wbv) pend[wbrd] = 0;
            if (iss && wen && rd != 0) pend[rd] = 1;
            if (md_left > 0) md_left--;
            if (iss && md) md_left = LAT;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin : stim
        for (int i = 0; i < 32; i++) pend[i] = 0;
        // Reset held with a valid instruction present.
        step(0, 1, 1, 1, 2, 1, 5, 1, 0, 0, 0, 0, 1'b0);
        step(0, 1, 1, 1, 2, 1, 5, 1, 0, 0, 0, 0);
        // add x5 issues on release, then RAW on x5 until writeback.
        step(1, 1, 1, 1, 2, 1, 5, 1, 0, 0, 0, 0);
        step(1, 1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 0);
        step(1, 1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 0);
        step(1, 1, 5, 1, 0, 0, 6, 1, 0, 1, 5, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6, 0);
        // x0 destination never tracked.
        step(1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        // WAW on x7, then same-cycle writeback with set winning.
        step(1, 1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 7, 1, 0, 1, 7, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0);
        // Mul/div occupancy and back-to-back structural stall.
        step(1, 1, 1, 1, 2, 1, 9, 1, 1, 0, 0, 0);
        for (int i = 0; i < 9; i++) step(1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        // Flush on a stalled instruction.
        step(1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
        step(1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
        idle(LAT);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0);
        // Reset in the middle of a mul/div with x3 pending.
        step(1, 1, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0);
        idle(2);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(LAT + 2);
        // Randomized traffic over a small register window to provoke hazards.
        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 199) != 0),
                 ($urandom_range(0, 3) != 0),
                 int'($urandom_range(0, 7)), 1'($urandom), int'($urandom_range(0, 7)), 1'($urandom),
                 int'($urandom_range(0, 7)), 1'($urandom),
                 ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 2) != 0), int'($urandom_range(0, 7)),
                 ($urandom_range(0, 15) == 0));
        end
        @(negedge clk);
        @(negedge clk);
        #4;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decode_issue_ctrl.md
Name: decode_issue_ctrl

Overview:
- Issue controller between the decode stage and execute in the in-order RISC-V pipeline.
- Keeps a per-register pending-write scoreboard and a sequencer for the multi-cycle mul/div unit.
- Decides each cycle whether the decoded instruction issues, stalls fetch/decode, or is replaced by a bubble in EX.
- Owns the stall/bubble/issue controls that gate the decode-to-execute pipeline register.

Parameters:
- NREG, 32, number of architectural integer registers tracked; x0 is never tracked.
- MULDIV_LAT, 8, mul/div occupancy in cycles from issue to done pulse; legal range 2..255.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- id_valid  in  1  decode stage holds a valid instruction
- id_rs1, id_rs2  in  5  source register indices
- id_use_rs1, id_use_rs2  in  1  the instruction reads rs1 / rs2
- id_rd  in  5  destination register index
- id_wen  in  1  the instruction writes rd
- id_is_muldiv  in  1  the instruction uses the mul/div unit
- wb_valid  in  1  writeback retires a register write this cycle
- wb_rd  in  5  writeback destination index
- flush  in  1  redirect from EX; kills the decode-stage instruction
- issue  out  1  decode instruction moves into EX this cycle
- stall_f, stall_d  out  1  hold the fetch and decode pipeline registers
- bubble_e  out  1  load a NOP into the EX pipeline register
- busy_vec  out  NREG  scoreboard; bit i set means a write to xi is pending
- muldiv_busy  out  1  mul/div sequencer is not IDLE
- muldiv_done  out  1  one-cycle pulse when mul/div occupancy ends

Behaviour:
- Reset: reset=0 sampled at a posedge clears busy_vec to 0, the FSM to IDLE and the counter to 0.
  - While reset=0: issue=0, stall_f=stall_d=0, bubble_e=1, muldiv_done=0.
  - Reset mid-operation abandons pending writes and the mul/div sequence; there is no recovery.
- Effective busy (combinational): eb = busy_vec with bit wb_rd cleared when wb_valid=1, and bit 0 always 0.
  - A same-cycle writeback therefore never causes a hazard; the register file writes through.
- Hazard conditions (any one is a hazard):
  - RAW: (id_use_rs1 & eb[id_rs1]) or (id_use_rs2 & eb[id_rs2]).
  - WAW: id_wen & id_rd!=0 & eb[id_rd].
  - Structural: id_is_muldiv & FSM!=IDLE.
- Control outputs (combinational):
  - issue = id_valid & !hazard & !flush.
  - stall_f = stall_d = id_valid & hazard & !flush. Flush overrides stall.
  - bubble_e = !issue.
- Scoreboard update at posedge (reset=1):
  - Start from busy_vec, clear bit wb_rd if wb_valid, then set bit id_rd if issue & id_wen & id_rd!=0.
  - Set wins over a same-cycle clear of the same index.
  - Bit 0 is always 0.
  - wb_valid with a non-busy wb_rd is harmless.
- Mul/div FSM:
  - IDLE: issue & id_is_muldiv -> BUSY, cnt = MULDIV_LAT-2.
  - BUSY: cnt!=0 -> cnt-1; cnt==0 -> DONE.
  - DONE: muldiv_done=1 for this cycle only, then -> IDLE. The next muldiv can issue in the following cycle.
  - Issue-to-done-pulse distance = MULDIV_LAT cycles.
  - muldiv_busy = (FSM != IDLE).
  - flush does not affect the FSM or the scoreboard; all in-flight instructions are older than the redirect.
- The mul/div result write arrives on the wb_* port like any other write; the FSM only models occupancy.

Test Plan:
- Reset: hold reset=0 for 2 cycles with id_valid=1 -> issue=0, bubble_e=1, busy_vec=0; release with an add x5 -> issue=1, busy_vec[5]=1 next cycle.
- RAW: issue a write to x5; next cycle, an instruction with rs1=5 and use_rs1=1 -> stall_f=stall_d=1, bubble_e=1 until the cycle where wb_valid=1, wb_rd=5, in which issue=1 with no extra stall.
- x0 and WAW: issue rd=0 -> busy_vec stays 0. With busy[7]=1, rd=7 wen=1 stalls; wb_rd=7 in the same cycle -> issue=1 and busy[7] remains 1 (set wins).
- Mul/div: MULDIV_LAT=8, issue mul at cycle t -> muldiv_busy=1 for t+1..t+8 and muldiv_done=1 at t+8. A second mul stalls until t+8 and issues at t+9.
- Flush: stalled instruction present with flush=1 -> issue=0, stall_d=0, bubble_e=1; busy_vec and the FSM are unchanged.
- Reset mid-op: assert reset while BUSY with busy[3]=1 -> FSM IDLE, busy_vec=0, no muldiv_done pulse afterwards.
